// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle sequencer for the CPU datapath.
//
// Each instruction is stepped through FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// The sequencer drives every datapath enable and select, and handshakes with
// the instruction and data memories. A watchdog on memory waits parks the
// sequencer in HALT if an ack never comes.
//
// Ports:
//   clk, rst            clock / synchronous active-high reset
//   inst                IR contents, opcode in inst[31:28], valid from DECODE on
//   imem_ack, dmem_ack  memory acks, honoured only while the matching req is high
//   alu_z, alu_n        ALU result flags (they only reach the flag register)
//   flag_z, flag_n      registered flags, used as branch conditions
//   imem_req, dmem_req  memory requests, held until ack
//   dmem_we             data write (ST), only together with dmem_req
//   ir_we, pc_we, rf_we, flag_we, illegal   single-cycle strobes
//   pc_sel, wb_sel, imm_sel, alu_op         datapath selects
//   timeout_err         sticky watchdog error
//   retired_cnt         retired-instruction counter, wraps
//   state_o             0 FETCH 1 DECODE 2 EXEC 3 MEM 4 WB 7 HALT
//
// Outputs that depend only on the state (requests, dmem_we) come from
// registers. Strobes that must fire in the cycle an ack arrives cannot be
// registered; they are decoded from the state and are masked while rst is
// high, so a reset never lets a strobe through.
module cpu_seq_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             flag_z,
    input  logic             flag_n,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [1:0]       imm_sel,
    output logic [3:0]       alu_op,
    output logic             flag_we,
    output logic             illegal,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_INC  = 4'h5;
    localparam logic [3:0] OP_NEG  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_BRZ  = 4'h9;
    localparam logic [3:0] OP_JM   = 4'hA;
    localparam logic [3:0] OP_BRN  = 4'hB;
    localparam logic [3:0] OP_LD   = 4'hE;
    localparam logic [3:0] OP_SVPC = 4'hF;

    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_reg, state_next;
    logic [3:0]       op_reg;
    logic [WD_W-1:0]  wdog_reg;
    logic             imem_req_reg, dmem_req_reg, dmem_we_reg;
    logic             timeout_reg;
    logic [CNT_W-1:0] retired_reg;

    logic       ir_we_c, pc_we_c, rf_we_c, flag_we_c, illegal_c, retire;
    logic [1:0] pc_sel_c, wb_sel_c;
    logic [3:0] op_cur;
    logic       stalled, wd_expire;

    // Only the opcode field matters to the sequencer; the ALU flags go
    // straight into the flag register elsewhere in the datapath.
    logic unused_inputs;
    assign unused_inputs = ^{inst[27:0], alu_z, alu_n};

    // The IR becomes valid in DECODE; after that the latched opcode is used.
    assign op_cur = (state_reg == S_DECODE) ? inst[31:28] : op_reg;

    // A request is stalled when it is live and unanswered this cycle.
    assign stalled   = (state_reg == S_FETCH && imem_req_reg && !imem_ack) ||
                       (state_reg == S_MEM   && dmem_req_reg && !dmem_ack);
    assign wd_expire = stalled && (wdog_reg == WD_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 2'b00;
        rf_we_c    = 1'b0;
        wb_sel_c   = 2'b00;
        flag_we_c  = 1'b0;
        illegal_c  = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (imem_req_reg && imem_ack) begin
                    ir_we_c    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (op_reg)
                    OP_ADD, OP_INC, OP_NEG, OP_SUB: begin
                        flag_we_c  = 1'b1;
                        state_next = S_WB;
                    end
                    OP_SVPC: state_next = S_WB;
                    OP_LD, OP_ST, OP_JM: state_next = S_MEM;
                    OP_J: begin
                        pc_we_c    = 1'b1;
                        pc_sel_c   = 2'b01;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_BRZ, OP_BRN: begin
                        pc_we_c    = 1'b1;
                        pc_sel_c   = ((op_reg == OP_BRZ) ? flag_z : flag_n) ? 2'b01 : 2'b00;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: begin
                        // NOP, and undecoded opcodes behave like a NOP
                        illegal_c  = (op_reg != OP_NOP);
                        pc_we_c    = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_req_reg && dmem_ack) begin
                    if (op_reg == OP_LD) begin
                        state_next = S_WB;
                    end else begin
                        pc_we_c    = 1'b1;
                        pc_sel_c   = (op_reg == OP_JM) ? 2'b10 : 2'b00;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we_c    = 1'b1;
                wb_sel_c   = (op_reg == OP_LD)   ? 2'b01 :
                             (op_reg == OP_SVPC) ? 2'b10 : 2'b00;
                pc_we_c    = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
        if (wd_expire) begin
            state_next = S_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            op_reg       <= 4'h0;
            wdog_reg     <= '0;
            imem_req_reg <= 1'b0;
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
            retired_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                op_reg <= inst[31:28];
            end
            // A stall never coincides with a state change, so anything else clears it.
            wdog_reg     <= (stalled && !wd_expire) ? wdog_reg + WD_W'(1) : '0;
            imem_req_reg <= (state_next == S_FETCH);
            dmem_req_reg <= (state_next == S_MEM);
            dmem_we_reg  <= (state_next == S_MEM) && (op_reg == OP_ST);
            if (wd_expire) begin
                timeout_reg <= 1'b1;
            end
            if (retire) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    assign imem_req    = imem_req_reg;
    assign dmem_req    = dmem_req_reg;
    assign dmem_we     = dmem_we_reg;
    assign ir_we       = ir_we_c   & ~rst;
    assign pc_we       = pc_we_c   & ~rst;
    assign rf_we       = rf_we_c   & ~rst;
    assign flag_we     = flag_we_c & ~rst;
    assign illegal     = illegal_c & ~rst;
    assign pc_sel      = pc_sel_c;
    assign wb_sel      = wb_sel_c;
    assign alu_op      = (state_reg == S_EXEC) ? op_reg : 4'h0;
    assign imm_sel     = (state_reg == S_DECODE || state_reg == S_EXEC ||
                          state_reg == S_MEM    || state_reg == S_WB)
                         ? ((op_cur == OP_SVPC) ? 2'b01 :
                            (op_cur == OP_INC)  ? 2'b10 : 2'b00)
                         : 2'b00;
    assign timeout_err = timeout_reg;
    assign retired_cnt = retired_reg;
    assign state_o     = state_reg;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed testbench for cpu_seq_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_cpu_seq_ctrl;

    localparam int MT = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   inst;
    logic          imem_ack, dmem_ack, alu_z, alu_n, flag_z, flag_n;
    logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, flag_we, illegal;
    logic [1:0]    pc_sel, wb_sel, imm_sel;
    logic [3:0]    alu_op;
    logic          timeout_err;
    logic [CW-1:0] retired_cnt;
    logic [2:0]    state_o;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_cnt;

    typedef struct {
        int          cycles;
        logic [31:0] seq;
        logic [1:0]  psel;
        int          rf_cnt;
        int          rf_cyc;
        logic [1:0]  wsel;
        logic [1:0]  isel;
        logic [3:0]  aop;
        logic [3:0]  aop_other;
        int          dreq_cyc;
        int          dwe_cnt;
        int          fl_cnt;
        int          ill_cnt;
        logic        done;
        logic        halted;
    } res_t;

    res_t r;

    cpu_seq_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .inst(inst),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .alu_z(alu_z), .alu_n(alu_n), .flag_z(flag_z), .flag_n(flag_n),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .imm_sel(imm_sel), .alu_op(alu_op),
        .flag_we(flag_we), .illegal(illegal), .timeout_err(timeout_err),
        .retired_cnt(retired_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction. Called at a sample point (posedge+1). idel/ddel are
    // the number of unanswered request cycles before each ack.
    task automatic run_instr(input logic [31:0] iw, input int idel, input int ddel, output res_t o);
        int iw_cnt = 0;
        int dw_cnt = 0;
        int guard  = 0;
        o.cycles = 0; o.seq = '0; o.psel = 2'b11; o.rf_cnt = 0; o.rf_cyc = 0;
        o.wsel = 2'b11; o.isel = 2'b11; o.aop = 4'h0; o.aop_other = 4'h0;
        o.dreq_cyc = 0; o.dwe_cnt = 0; o.fl_cnt = 0; o.ill_cnt = 0;
        o.done = 1'b0; o.halted = 1'b0;
        inst = iw;
        while (!imem_req && guard < 5) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int c = 1; c <= 40 && !o.done; c++) begin
            imem_ack = (state_o == 3'd0) && imem_req && (iw_cnt >= idel);
            dmem_ack = (state_o == 3'd3) && dmem_req && (dw_cnt >= ddel);
            #1;
            o.cycles = c;
            o.seq    = (o.seq << 3) | {29'd0, state_o};
            if (imem_req) iw_cnt++;
            if (dmem_req) begin dw_cnt++; o.dreq_cyc++; end
            if (dmem_we) o.dwe_cnt++;
            if (state_o == 3'd1) o.isel = imm_sel;
            if (state_o == 3'd2) o.aop = alu_op; else o.aop_other = o.aop_other | alu_op;
            if (rf_we) begin o.rf_cnt++; o.rf_cyc = c; o.wsel = wb_sel; end
            if (flag_we) o.fl_cnt++;
            if (illegal) o.ill_cnt++;
            if (pc_we) begin o.psel = pc_sel; o.done = 1'b1; end
            if (state_o == 3'd7) begin o.halted = 1'b1; break; end
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        $display("txn inst=%08h cycles=%0d seq=%0o pc_sel=%0d rf_we=%0d done=%0d halted=%0d retired=%0d",
                 iw, o.cycles, o.seq, o.psel, o.rf_cnt, o.done, o.halted, retired_cnt);
    endtask

    initial begin
        rst = 1'b1; inst = 32'h0; imem_ack = 1'b0; dmem_ack = 1'b0;
        alu_z = 1'b0; alu_n = 1'b0; flag_z = 1'b0; flag_n = 1'b0;
        exp_cnt = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        chk("rst_state", {29'd0, state_o}, 32'd0);
        chk("rst_cnt", {28'd0, retired_cnt}, 32'd0);
        chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
        chk("rst_outs", {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, flag_we, illegal,
                         pc_sel, wb_sel, imm_sel, alu_op}, 32'd0);
        rst = 1'b0;
        #1;
        chk("first_low_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        chk("req_rises", {31'd0, imem_req}, 32'd1);

        // ADD
        run_instr(32'h4123_4567, 0, 0, r);
        exp_cnt++;
        chk("add_seq", r.seq, 32'o0124);
        chk("add_rfcyc", r.rf_cyc, 32'd4);
        chk("add_flwe", r.fl_cnt, 32'd1);
        chk("add_aluop", {28'd0, r.aop}, 32'h4);
        chk("add_aluop_other", {28'd0, r.aop_other}, 32'h0);
        chk("add_cnt", {28'd0, retired_cnt}, {28'd0, exp_cnt});

        // LD, dmem ack delayed 3 cycles
        run_instr(32'hE000_0010, 0, 3, r);
        exp_cnt++;
        chk("ld_cycles", r.cycles, 32'd8);
        chk("ld_seq", r.seq, 32'o01233334);
        chk("ld_dreq", r.dreq_cyc, 32'd4);
        chk("ld_dwe", r.dwe_cnt, 32'd0);
        chk("ld_wbsel", {30'd0, r.wsel}, 32'd1);
        chk("ld_cnt", {28'd0, retired_cnt}, {28'd0, exp_cnt});

        // BRZ taken / not taken, BRN taken
        flag_z = 1'b1;
        run_instr(32'h9000_0000, 0, 0, r);
        exp_cnt++;
        chk("brz1_psel", {30'd0, r.psel}, 32'd1);
        chk("brz1_cycles", r.cycles, 32'd3);
        chk("brz1_rf", r.rf_cnt, 32'd0);
        flag_z = 1'b0;
        run_instr(32'h9000_0000, 1, 0, r);
        exp_cnt++;
        chk("brz0_psel", {30'd0, r.psel}, 32'd0);
        chk("brz0_cycles", r.cycles, 32'd4);
        chk("brz0_rf", r.rf_cnt, 32'd0);
        flag_n = 1'b1;
        run_instr(32'hB000_0000, 0, 0, r);
        exp_cnt++;
        chk("brn1_psel", {30'd0, r.psel}, 32'd1);
        flag_n = 1'b0;

        // SVPC, INC, illegal opcode
        run_instr(32'hF020_0000, 0, 0, r);
        exp_cnt++;
        chk("svpc_isel", {30'd0, r.isel}, 32'd1);
        chk("svpc_wbsel", {30'd0, r.wsel}, 32'd2);
        chk("svpc_cycles", r.cycles, 32'd4);
        run_instr(32'h5000_FFFF, 0, 0, r);
        exp_cnt++;
        chk("inc_isel", {30'd0, r.isel}, 32'd2);
        chk("inc_wbsel", {30'd0, r.wsel}, 32'd0);
        run_instr(32'h1000_0000, 0, 0, r);
        exp_cnt++;
        chk("ill_pulse", r.ill_cnt, 32'd1);
        chk("ill_psel", {30'd0, r.psel}, 32'd0);
        chk("ill_cycles", r.cycles, 32'd3);
        chk("ill_cnt", {28'd0, retired_cnt}, {28'd0, exp_cnt});

        // ST and JM
        run_instr(32'h3000_0000, 0, 0, r);
        exp_cnt++;
        chk("st_seq", r.seq, 32'o0123);
        chk("st_dwe", r.dwe_cnt, 32'd1);
        chk("st_psel", {30'd0, r.psel}, 32'd0);
        chk("st_rf", r.rf_cnt, 32'd0);
        run_instr(32'hA000_0000, 0, 1, r);
        exp_cnt++;
        chk("jm_psel", {30'd0, r.psel}, 32'd2);
        chk("jm_cycles", r.cycles, 32'd5);
        chk("jm_dwe", r.dwe_cnt, 32'd0);
        chk("jm_cnt", {28'd0, retired_cnt}, {28'd0, exp_cnt});

        // reset in the middle of a fetch wait, with a simultaneous ack
        inst = 32'h0;
        chk("mid_req_live", {31'd0, imem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; imem_ack = 1'b1;
        #1;
        chk("mid_rst_irwe", {31'd0, ir_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 4'd0;
        #1;
        chk("mid_req_drop", {31'd0, imem_req}, 32'd0);
        chk("stray_irwe", {31'd0, ir_we}, 32'd0);
        chk("mid_cnt", {28'd0, retired_cnt}, 32'd0);
        @(posedge clk); #1;
        chk("stray_state", {29'd0, state_o}, 32'd0);
        imem_ack = 1'b0;

        // counter wrap: 15 NOPs, then one more
        for (int i = 0; i < 15; i++) begin
            run_instr(32'h0000_0000, 0, 0, r);
            exp_cnt++;
        end
        chk("cnt_max", {28'd0, retired_cnt}, 32'd15);
        run_instr(32'h8000_0000, 0, 0, r);
        exp_cnt++;
        chk("j_psel", {30'd0, r.psel}, 32'd1);
        chk("cnt_wrap", {28'd0, retired_cnt}, {28'd0, exp_cnt});

        // watchdog: dmem ack never arrives
        run_instr(32'hE000_0000, 0, 1000, r);
        chk("tmo_halted", {31'd0, r.halted}, 32'd1);
        chk("tmo_dreq", r.dreq_cyc, 32'd4);
        chk("tmo_seq", r.seq, 32'o01233337);
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("halt_state", {29'd0, state_o}, 32'd7);
        chk("halt_outs", {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, flag_we, illegal,
                          pc_sel, wb_sel, imm_sel, alu_op}, 32'd0);
        chk("halt_err", {31'd0, timeout_err}, 32'd1);
        chk("halt_cnt", {28'd0, retired_cnt}, {28'd0, exp_cnt});
        imem_ack = 1'b0; dmem_ack = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_state", {29'd0, state_o}, 32'd0);
        chk("post_rst_err", {31'd0, timeout_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
